// File: rtl/adc_cap_width_pack_pkg.sv
// Shared types and constants for the ADC capture framer / 192->128 packer.
package adc_cap_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} cap_state_t;
  localparam int BYTES_PER_BEAT = 16;
  localparam int PHASES         = 3;
endpackage

// File: rtl/adc_cap_width_pack.sv
// Capture framer: drains ADC beats while idle, then packs cap_size bytes of 3/2-wide
// input into OUT_W output beats with tlast on the final one.
module adc_cap_width_pack
  import adc_cap_pkg::*;
#(
  parameter int OUT_W = 128,
  parameter int CNT_W = 28
) (
  input  logic                   ps_clk,
  input  logic                   ps_rst,
  input  logic                   cap_start,
  input  logic                   cap_abort,
  input  logic [31:0]            cap_size,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [3*OUT_W/2-1:0]   s_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [OUT_W-1:0]       m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   cap_busy,
  output logic                   cap_done,
  output logic [CNT_W-1:0]       beats_sent
);
  localparam int IN_W = 3*OUT_W/2;
  localparam int HALF = OUT_W/2;

  cap_state_t        state_q, state_d;
  logic [1:0]        ph_q, ph_d;
  logic [OUT_W-1:0]  res_q, res_d;
  logic [OUT_W-1:0]  obuf_q, obuf_d;
  logic              ov_q, ov_d;
  logic              tlast_q, tlast_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic              rdy_q;

  logic              load_ok, m_hs, load;
  logic [OUT_W-1:0]  ld_data;
  logic [CNT_W-1:0]  n_in;
  logic              unused_ok;

  assign n_in      = cap_size[CNT_W+3:4];
  assign unused_ok = ^cap_size[3:0];
  assign load_ok   = !ov_q || m_axis_tready;
  assign m_hs      = ov_q && m_axis_tready;

  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    res_d         = res_q;
    obuf_d        = obuf_q;
    ov_d          = ov_q;
    tlast_d       = tlast_q;
    n_d           = n_q;
    cnt_d         = cnt_q;
    beats_d       = m_hs ? beats_q + 1'b1 : beats_q;
    s_axis_tready = 1'b0;
    load          = 1'b0;
    ld_data       = '0;

    case (state_q)
      IDLE: begin
        s_axis_tready = rdy_q;
        if (cap_start && n_in != '0) begin
          n_d     = n_in;
          cnt_d   = '0;
          beats_d = '0;
          ph_d    = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (m_hs) ov_d = 1'b0;
        case (ph_q)
          2'd0: begin
            s_axis_tready = load_ok;
            if (s_axis_tvalid && load_ok) begin
              load    = 1'b1;
              ld_data = s_axis_tdata[OUT_W-1:0];
              res_d   = {{HALF{1'b0}}, s_axis_tdata[IN_W-1:OUT_W]};
              ph_d    = 2'd1;
            end
          end
          2'd1: begin
            s_axis_tready = load_ok;
            if (s_axis_tvalid && load_ok) begin
              load    = 1'b1;
              ld_data = {s_axis_tdata[HALF-1:0], res_q[HALF-1:0]};
              res_d   = s_axis_tdata[IN_W-1:HALF];
              ph_d    = 2'd2;
            end
          end
          default: begin
            // third output of each input pair comes purely from the residue
            if (load_ok) begin
              load    = 1'b1;
              ld_data = res_q;
              ph_d    = 2'd0;
            end
          end
        endcase
        if (load) begin
          obuf_d = ld_data;
          ov_d   = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == n_q - 1'b1) begin
            tlast_d = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (m_hs) begin
          ov_d    = 1'b0;
          tlast_d = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap_abort) begin
      state_d = IDLE;
      ov_d    = 1'b0;
      tlast_d = 1'b0;
      ph_d    = 2'd0;
      res_d   = '0;
    end
  end

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) begin
      state_q <= IDLE;
      ph_q    <= 2'd0;
      res_q   <= '0;
      obuf_q  <= '0;
      ov_q    <= 1'b0;
      tlast_q <= 1'b0;
      n_q     <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      res_q   <= res_d;
      obuf_q  <= obuf_d;
      ov_q    <= ov_d;
      tlast_q <= tlast_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      rdy_q   <= 1'b1;
    end
  end

  assign m_axis_tvalid = ov_q;
  assign m_axis_tdata  = obuf_q;
  assign m_axis_tlast  = tlast_q;
  assign cap_busy      = (state_q == RUN) || (state_q == FLUSH);
  assign cap_done      = (state_q == DONE);
  assign beats_sent    = beats_q;
endmodule

// File: tb/tb_adc_cap_width_pack.sv
// Scoreboard bench: output beats must be consecutive 16-byte slices of the accepted input byte stream.
module tb_adc_cap_width_pack;
  localparam int OUT_W = 128;
  localparam int IN_W  = 192;
  localparam int CNT_W = 28;

  logic             ps_clk, ps_rst, cap_start, cap_abort;
  logic [31:0]      cap_size;
  logic             s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, cap_busy, cap_done;
  logic [IN_W-1:0]  s_tdata;
  logic [OUT_W-1:0] m_tdata;
  logic [CNT_W-1:0] beats_sent;

  int checks = 0, failures = 0;

  adc_cap_width_pack #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .ps_clk(ps_clk), .ps_rst(ps_rst), .cap_start(cap_start), .cap_abort(cap_abort),
    .cap_size(cap_size), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .cap_busy(cap_busy),
    .cap_done(cap_done), .beats_sent(beats_sent)
  );

  initial ps_clk = 1'b0;
  always #5 ps_clk = ~ps_clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // reference model: byte stream of accepted capture input, sliced into 16-byte beats
  logic [7:0]   bq[$];
  bit           armed = 0, done_pend = 0, prev_stall = 0, prev_last = 0, prev_abort = 0;
  logic [127:0] prev_data;
  int           n_exp = 0, beat_idx = 0, caps_done = 0, last_n = 0;

  always @(negedge ps_clk) begin
    logic [127:0] exp;
    bit           was_busy;
    if (ps_rst) begin
      armed = 0; done_pend = 0; prev_stall = 0; prev_abort = 0; bq.delete();
    end else begin
      was_busy = armed || done_pend;
      if (prev_stall && !prev_abort) begin
        chk("stall_valid", m_tvalid, 1'b1);
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", m_tlast, prev_last);
      end
      if (done_pend || cap_done) begin
        chk("cap_done", cap_done, done_pend);
        if (done_pend) chk("beats_sent_done", beats_sent, last_n);
      end
      if (cap_done) caps_done++;
      done_pend = 0;
      if (armed && s_tvalid && s_tready)
        for (int i = 0; i < 24; i++) bq.push_back(s_tdata[i*8 +: 8]);
      if (m_tvalid && m_tready) begin
        if (!armed) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=valid_beat required=no_beat");
        end else if (bq.size() < 16) begin
          checks++; failures++;
          $display("FAIL data_underrun actual=%0d_bytes required=16_bytes", bq.size());
        end else begin
          for (int i = 0; i < 16; i++) exp[i*8 +: 8] = bq.pop_front();
          chk("tdata", m_tdata, exp);
          chk("tlast", m_tlast, (beat_idx == n_exp - 1));
          chk("beats_sent", beats_sent, beat_idx);
          beat_idx++;
          if (beat_idx == n_exp) begin
            armed = 0; bq.delete(); done_pend = 1; last_n = beat_idx;
          end
        end
      end
      if (cap_abort) begin
        armed = 0; bq.delete();
      end else if (cap_start && !was_busy && (cap_size >> 4) != 0) begin
        armed = 1; n_exp = int'(cap_size >> 4); beat_idx = 0; bq.delete();
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_abort = cap_abort;
    end
  end

  logic [7:0] ib = 8'd0;

  task automatic drive_cycle(input int tv, input int tr, input bit inc);
    s_tvalid = ($urandom_range(99) < tv);
    m_tready = ($urandom_range(99) < tr);
    for (int i = 0; i < 24; i++) s_tdata[i*8 +: 8] = inc ? ib + 8'(i) : 8'($urandom);
    ib += 8'd24;
    @(posedge ps_clk); #1;
  endtask

  task automatic start_cap(input logic [31:0] sz);
    s_tvalid = 1'b0; cap_start = 1'b1; cap_size = sz;
    @(posedge ps_clk); #1;
    cap_start = 1'b0;
  endtask

  task automatic do_abort(input bit with_start);
    cap_abort = 1'b1; cap_start = with_start; cap_size = 32'd64;
    s_tvalid = 1'b0; m_tready = 1'b0;
    @(posedge ps_clk); #1;
    cap_abort = 1'b0; cap_start = 1'b0;
    @(negedge ps_clk);
    chk("abort_tvalid", m_tvalid, 1'b0);
    chk("abort_busy", cap_busy, 1'b0);
    chk("abort_tlast", m_tlast, 1'b0);
    @(posedge ps_clk); #1;
  endtask

  // runs until cap_done is observed, optionally aborting at a beat or pulsing a mid-run start
  task automatic run_cap(input int tv, input int tr, input bit inc, input int abort_at,
                         input bit mid_start);
    int c0, cyc;
    c0 = caps_done; cyc = 0;
    while (caps_done == c0 && cyc < 20000) begin
      if (abort_at >= 0 && beat_idx >= abort_at) begin
        do_abort(1'b0);
        return;
      end
      if (mid_start && cyc == 5) begin cap_start = 1'b1; cap_size = 32'd1600; end
      drive_cycle(tv, tr, inc);
      cap_start = 1'b0;
      cyc++;
    end
    if (caps_done == c0) begin
      checks++; failures++;
      $display("FAIL timeout actual=no_cap_done required=cap_done");
    end
  endtask

  initial begin
    ps_rst = 1'b1; cap_start = 1'b0; cap_abort = 1'b0; cap_size = '0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    repeat (3) @(posedge ps_clk);
    #1;
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_busy", cap_busy, 1'b0);
    chk("rst_beats", beats_sent, '0);
    ps_rst = 1'b0;
    repeat (2) @(posedge ps_clk);
    #1;
    chk("idle_s_tready", s_tready, 1'b1);

    // T1 / T2: full-rate captures, 6 and 5 beats
    start_cap(32'd96);
    run_cap(100, 100, 1'b1, -1, 1'b0);
    @(negedge ps_clk);
    chk("t1_beats", beats_sent, 6);
    chk("t1_idle_busy", cap_busy, 1'b0);
    start_cap(32'd80);
    run_cap(100, 100, 1'b0, -1, 1'b0);
    @(negedge ps_clk);
    chk("t2_beats", beats_sent, 5);
    chk("t2_idle_ready", s_tready, 1'b1);

    // T3: random stalls on both sides
    start_cap(32'd4800);
    run_cap(60, 50, 1'b0, -1, 1'b0);
    @(negedge ps_clk);
    chk("t3_beats", beats_sent, 300);

    // T4: abort mid-capture then a short realigned capture
    start_cap(32'd1600);
    run_cap(70, 70, 1'b0, 10, 1'b0);
    start_cap(32'd32);
    run_cap(100, 100, 1'b0, -1, 1'b0);
    @(negedge ps_clk);
    chk("t4_beats", beats_sent, 2);

    // T5: undersized start, start during RUN, start+abort together
    start_cap(32'd15);
    repeat (3) drive_cycle(50, 50, 1'b0);
    chk("t5_small_busy", cap_busy, 1'b0);
    start_cap(32'd64);
    run_cap(80, 80, 1'b0, -1, 1'b1);
    @(negedge ps_clk);
    chk("t5_mid_start_beats", beats_sent, 4);
    start_cap(32'd1600);
    repeat (8) drive_cycle(80, 80, 1'b0);
    do_abort(1'b1);
    do_abort(1'b1);

    // T6: asynchronous reset in the middle of a capture
    start_cap(32'd4800);
    repeat (20) drive_cycle(80, 60, 1'b0);
    #2 ps_rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", m_tvalid, 1'b0);
    chk("t6_rst_tdata", m_tdata, '0);
    chk("t6_rst_busy", cap_busy, 1'b0);
    chk("t6_rst_beats", beats_sent, '0);
    chk("t6_rst_s_tready", s_tready, 1'b0);
    repeat (2) @(posedge ps_clk);
    #1 ps_rst = 1'b0;
    repeat (2) @(posedge ps_clk);
    #1;
    start_cap(32'd48);
    run_cap(90, 90, 1'b0, -1, 1'b0);
    @(negedge ps_clk);
    chk("t6_beats", beats_sent, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
